// File: rtl/mux_n_1_reg.sv
// Registered N:1 multiplexer with a manual-select mode and a round-robin auto-scan mode
// that dwells a programmable number of cycles per channel, plus a hold that freezes everything.
module mux_n_1_reg #(
    parameter  int CH_NUM = 4,
    parameter  int DATA_W = 1,
    parameter  int DWELL  = 10,
    localparam int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [CH_NUM*DATA_W-1:0]   in_bus,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       mode,
    input  logic                       hold,
    output logic [DATA_W-1:0]          out,
    output logic [SEL_W-1:0]           out_ch,
    output logic                       ch_switch,
    output logic                       sel_err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SEL_W:0]   CH_NUM_EXT = (SEL_W + 1)'(CH_NUM);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic               ch_switch_q, ch_switch_d;
    logic               sel_err_q, sel_err_d;

    logic [SEL_W-1:0]   nxt_s;
    logic               sel_ok_s;
    logic [DATA_W-1:0]  ch_data_s [CH_NUM];

    genvar k;
    for (k = 0; k < CH_NUM; k++) begin : g_ch
        assign ch_data_s[k] = in_bus[k*DATA_W +: DATA_W];
    end

    assign sel_ok_s = ({1'b0, sel} < CH_NUM_EXT);

    // Next-channel selection, dwell counting and mode tracking.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nxt_s     = out_ch_q;
        sel_err_d = sel_err_q;
        if (hold) begin
            nxt_s = out_ch_q;
        end else if (!mode) begin
            state_d = ST_MANUAL;
            cnt_d   = {CNT_W{1'b0}};
            if (sel_ok_s) begin
                nxt_s     = sel;
                sel_err_d = 1'b0;
            end else begin
                nxt_s     = out_ch_q;
                sel_err_d = 1'b1;
            end
        end else begin
            state_d   = ST_SCAN;
            sel_err_d = 1'b0;
            case (state_q)
                // Entering scan: the current channel gets a full dwell first.
                ST_MANUAL: begin
                    cnt_d = {CNT_W{1'b0}};
                    nxt_s = out_ch_q;
                end
                ST_SCAN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = {CNT_W{1'b0}};
                        nxt_s = (out_ch_q == LAST_CH) ? {SEL_W{1'b0}} : out_ch_q + SEL_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        nxt_s = out_ch_q;
                    end
                end
                default: begin
                    cnt_d = {CNT_W{1'b0}};
                    nxt_s = out_ch_q;
                end
            endcase
        end
    end

    // Output-side next values; hold keeps the data register from tracking in_bus.
    always_comb begin
        out_ch_d = nxt_s;
        if (hold) begin
            out_d       = out_q;
            ch_switch_d = 1'b0;
        end else begin
            out_d       = ch_data_s[nxt_s];
            ch_switch_d = (nxt_s != out_ch_q);
        end
    end

    // State, counter and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_MANUAL;
            cnt_q       <= {CNT_W{1'b0}};
            out_ch_q    <= {SEL_W{1'b0}};
            out_q       <= {DATA_W{1'b0}};
            ch_switch_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_ch_q    <= out_ch_d;
            out_q       <= out_d;
            ch_switch_q <= ch_switch_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign ch_switch = ch_switch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Directed bench for mux_n_1_reg: three instances cover manual select, out-of-range select,
// scan with wrap, hold, mode switching, mid-dwell reset and single-cycle dwell.
module tb_mux_n_1_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: 4 channels x 8 bits, dwell 3
    logic [31:0] a_bus;
    logic [1:0]  a_sel;
    logic        a_mode, a_hold;
    logic [7:0]  a_out;
    logic [1:0]  a_ch;
    logic        a_sw, a_err;

    // Instance B: 3 channels x 8 bits, dwell 3
    logic [23:0] b_bus;
    logic [1:0]  b_sel;
    logic        b_mode, b_hold;
    logic [7:0]  b_out;
    logic [1:0]  b_ch;
    logic        b_sw, b_err;

    // Instance C: 5 channels x 8 bits, dwell 1
    logic [39:0] c_bus;
    logic [2:0]  c_sel;
    logic        c_mode, c_hold;
    logic [7:0]  c_out;
    logic [2:0]  c_ch;
    logic        c_sw, c_err;

    mux_n_1_reg #(.CH_NUM(4), .DATA_W(8), .DWELL(3)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_bus(a_bus), .sel(a_sel), .mode(a_mode),
        .hold(a_hold), .out(a_out), .out_ch(a_ch), .ch_switch(a_sw), .sel_err(a_err));

    mux_n_1_reg #(.CH_NUM(3), .DATA_W(8), .DWELL(3)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_bus(b_bus), .sel(b_sel), .mode(b_mode),
        .hold(b_hold), .out(b_out), .out_ch(b_ch), .ch_switch(b_sw), .sel_err(b_err));

    mux_n_1_reg #(.CH_NUM(5), .DATA_W(8), .DWELL(1)) u_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_bus(c_bus), .sel(c_sel), .mode(c_mode),
        .hold(c_hold), .out(c_out), .out_ch(c_ch), .ch_switch(c_sw), .sel_err(c_err));

    int total = 0;
    int bad   = 0;

    int scan_ch [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    int scan_sw [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int rel_ch  [4]  = '{0, 0, 0, 1};
    int rel_sw  [4]  = '{0, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        a_bus  = 32'hD4C3B2A1; a_sel = 2'd0; a_mode = 1'b0; a_hold = 1'b0;
        b_bus  = 24'h332211;   b_sel = 2'd0; b_mode = 1'b0; b_hold = 1'b0;
        c_bus  = 40'h5544332211; c_sel = 3'd0; c_mode = 1'b0; c_hold = 1'b0;
        tick();
        tick();
        chk("rst_out", 32'(a_out), 32'h0);
        chk("rst_ch",  32'(a_ch),  32'h0);
        chk("rst_sw",  32'(a_sw),  32'h0);
        chk("rst_err", 32'(a_err), 32'h0);

        // Manual selection on A
        rst_n = 1'b1;
        tick();
        chk("a_m0_out", 32'(a_out), 32'hA1);
        chk("a_m0_ch",  32'(a_ch),  32'h0);
        a_sel = 2'd2;
        tick();
        chk("a_s2_out", 32'(a_out), 32'hC3);
        chk("a_s2_ch",  32'(a_ch),  32'h2);
        chk("a_s2_sw",  32'(a_sw),  32'h1);
        tick();
        chk("a_s2_sw_once", 32'(a_sw), 32'h0);
        chk("a_s2_out2",    32'(a_out), 32'hC3);
        a_sel = 2'd3;
        tick();
        chk("a_s3_out", 32'(a_out), 32'hD4);
        chk("a_s3_ch",  32'(a_ch),  32'h3);
        a_bus[31:24] = 8'h5A;
        chk("a_bus_lat_before", 32'(a_out), 32'hD4);
        tick();
        chk("a_bus_lat_after", 32'(a_out), 32'h5A);
        chk("a_bus_lat_sw",    32'(a_sw),  32'h0);

        // Asynchronous reset mid-cycle
        a_sel = 2'd0;
        rst_n = 1'b0;
        #2;
        chk("a_async_out", 32'(a_out), 32'h0);
        chk("a_async_ch",  32'(a_ch),  32'h0);
        rst_n = 1'b1;
        tick();
        chk("a_rel_out", 32'(a_out), 32'hA1);

        // Out-of-range select on B
        b_sel = 2'd1;
        tick();
        chk("b_s1_ch",  32'(b_ch),  32'h1);
        chk("b_s1_out", 32'(b_out), 32'h22);
        chk("b_s1_sw",  32'(b_sw),  32'h1);
        tick();
        b_sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("b_oor_ch",  32'(b_ch),  32'h1);
            chk("b_oor_err", 32'(b_err), 32'h1);
            chk("b_oor_sw",  32'(b_sw),  32'h0);
            chk("b_oor_out", 32'(b_out), 32'h22);
        end
        b_sel = 2'd0;
        tick();
        chk("b_back_ch",  32'(b_ch),  32'h0);
        chk("b_back_err", 32'(b_err), 32'h0);
        chk("b_back_out", 32'(b_out), 32'h11);

        // Scan with wrap on B
        b_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b_scan_ch",  32'(b_ch),  32'(scan_ch[i]));
            chk("b_scan_sw",  32'(b_sw),  32'(scan_sw[i]));
            chk("b_scan_out", 32'(b_out), 32'(scan_ch[i] * 17 + 17));
        end
        tick();
        tick();
        tick();
        chk("b_pre_hold_ch", 32'(b_ch), 32'h1);
        chk("b_pre_hold_sw", 32'(b_sw), 32'h1);
        tick();
        chk("b_hold_entry_ch", 32'(b_ch), 32'h1);

        // Hold in the second dwell cycle of channel 1
        b_hold = 1'b1;
        b_bus[15:8] = 8'h99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_hold_ch",  32'(b_ch),  32'h1);
            chk("b_hold_sw",  32'(b_sw),  32'h0);
            chk("b_hold_out", 32'(b_out), 32'h22);
            chk("b_hold_err", 32'(b_err), 32'h0);
        end
        b_hold = 1'b0;
        tick();
        chk("b_unhold_ch",  32'(b_ch),  32'h1);
        chk("b_unhold_out", 32'(b_out), 32'h99);
        tick();
        chk("b_adv_ch",  32'(b_ch),  32'h2);
        chk("b_adv_sw",  32'(b_sw),  32'h1);
        chk("b_adv_out", 32'(b_out), 32'h33);

        // Scan to manual
        b_sel  = 2'd1;
        b_mode = 1'b0;
        tick();
        chk("b_s2m_ch",  32'(b_ch),  32'h1);
        chk("b_s2m_sw",  32'(b_sw),  32'h1);
        chk("b_s2m_out", 32'(b_out), 32'h99);
        b_mode = 1'b1;
        tick();
        chk("b_m2s_ch", 32'(b_ch), 32'h1);
        chk("b_m2s_sw", 32'(b_sw), 32'h0);
        tick();

        // Reset mid-dwell, then a full dwell on channel 0
        rst_n = 1'b0;
        #2;
        chk("b_rst_ch",  32'(b_ch),  32'h0);
        chk("b_rst_out", 32'(b_out), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_rel_ch",  32'(b_ch),  32'(rel_ch[i]));
            chk("b_rel_sw",  32'(b_sw),  32'(rel_sw[i]));
            chk("b_rel_out", 32'(b_out), (rel_ch[i] == 0) ? 32'h11 : 32'h99);
        end

        // C: boundary select, then single-cycle dwell scan
        c_sel = 3'd4;
        tick();
        chk("c_s4_ch",  32'(c_ch),  32'h4);
        chk("c_s4_err", 32'(c_err), 32'h0);
        chk("c_s4_out", 32'(c_out), 32'h55);
        c_sel = 3'd5;
        tick();
        chk("c_s5_ch",  32'(c_ch),  32'h4);
        chk("c_s5_err", 32'(c_err), 32'h1);
        chk("c_s5_sw",  32'(c_sw),  32'h0);
        c_sel = 3'd0;
        tick();
        chk("c_s0_ch",  32'(c_ch),  32'h0);
        chk("c_s0_err", 32'(c_err), 32'h0);
        c_mode = 1'b1;
        tick();
        chk("c_scan0_ch", 32'(c_ch), 32'h0);
        chk("c_scan0_sw", 32'(c_sw), 32'h0);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("c_scan_ch",  32'(c_ch),  32'(i % 5));
            chk("c_scan_sw",  32'(c_sw),  32'h1);
            chk("c_scan_out", 32'(c_out), 32'((i % 5) * 17 + 17));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_1_reg.md
Name: mux_n_1_reg

Overview:
- Parametrised N:1 multiplexer. Successor to the combinational 2:1 mux.
- Output and channel-index registers give one-cycle latency.
- Two modes: manual select, and auto-scan round-robin with a programmable dwell per channel.
- Sits between multi-source sampling logic (keys, sensor bits, LED patterns) and a single downstream consumer; exposes the active channel and a switch strobe.

Parameters:
- CH_NUM, 4, number of input channels, 2..16; need not be a power of two.
- DATA_W, 1, bits per channel.
- DWELL, 10, clock cycles spent on each channel in scan mode; must be ≥1.
- SEL_W, derived localparam = max(1, clog2(CH_NUM)); not overridable.

Ports:
- sys_clk  in  1  system clock, rising-edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_bus  in  CH_NUM*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- sel  in  SEL_W  manual channel select; sampled every cycle in manual mode.
- mode  in  1  0 = manual, 1 = auto-scan.
- hold  in  1  1 = freeze all state and outputs.
- out  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  channel currently driving out.
- ch_switch  out  1  one-cycle pulse when out_ch changes.
- sel_err  out  1  registered flag: manual sel ≥ CH_NUM this cycle.

Behaviour:
- Reset (sys_rst_n low, asynchronous): out=0, out_ch=0, ch_switch=0, sel_err=0, dwell counter=0, state=MANUAL.
- Release takes effect on the first rising edge with sys_rst_n high.
- States: MANUAL, SCAN.
  - State is loaded from mode each edge when hold=0.
  - Under hold=1 the state register also freezes.
- Per edge, next channel nxt is computed, then: out_ch<=nxt; out<=in_bus slice[nxt]; ch_switch<=(nxt!=out_ch).
  - Latency: a change on sel or in_bus appears on out exactly one edge later.
- MANUAL:
  - sel<CH_NUM: nxt=sel, sel_err<=0.
  - sel≥CH_NUM: nxt=out_ch (hold previous channel); out still re-samples that channel's data; sel_err<=1 for every such cycle.
  - Dwell counter is held at 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1: counter<=0, nxt=out_ch+1, wrapping from CH_NUM-1 to 0.
  - Otherwise nxt=out_ch and counter increments.
  - sel is ignored and sel_err<=0.
  - DWELL=1: channel advances every edge.
- MANUAL→SCAN (mode rises): counter cleared to 0 on that edge; scanning starts from the current out_ch, which dwells a full DWELL cycles before advancing.
- SCAN→MANUAL (mode falls): on that edge nxt=sel under manual rules; counter cleared.
- hold=1 has priority over everything except reset:
  - out, out_ch, counter, state and sel_err retain their values.
  - ch_switch<=0.
  - in_bus changes are not tracked while held.
  - On release, operation resumes from the frozen counter value.
- No combinational path from any input to any output.

Test Plan:
- Reset / manual select (CH_NUM=4, DATA_W=8, in_bus={8'hD4,8'hC3,8'hB2,8'hA1}): assert sys_rst_n=0 mid-cycle → out=0 and out_ch=0 immediately. Release, then sel=2 → one edge later out=8'hC3, out_ch=2, ch_switch=1 for exactly one cycle. Then sel=3 → out=8'hD4 the next edge.
- Out-of-range select (CH_NUM=3): out_ch=1, then sel=3 for 2 cycles → out_ch stays 1, sel_err=1 for 2 cycles, ch_switch=0. Then sel=0 → out_ch=0, sel_err=0.
- Scan and wrap (CH_NUM=3, DWELL=3): mode=1 from out_ch=0 → out_ch sequence per edge is 0,0,0,1,1,1,2,2,2,0…; ch_switch pulses on each transition, including 2→0.
- Hold mid-scan: hold=1 for 5 cycles in the 2nd cycle of channel 1's dwell → out_ch stays 1, ch_switch=0, and in_bus changes do not reach out. After release, channel 1 lasts 1 more cycle before advancing to 2.
- Mode switch and reset mid-scan:
  - SCAN at out_ch=2 with sel=1, mode→0 → next edge out_ch=1.
  - Separately, sys_rst_n pulsed low mid-dwell → out_ch=0 and counter=0. After release with mode=1, channel 0 dwells a full DWELL.
- DWELL=1, CH_NUM=5: mode=1 → out_ch advances 0,1,2,3,4,0 on consecutive edges; ch_switch stays high continuously.
